apb_master_arbiter: RTL and testbench

Multi-master front end for the APB NoC slave port. It accepts simple hold-until-ack transfer requests from `N_MASTER` requesters and grants them round-robin. It drives the winner's transfer onto a single APB master interface (IDLE/SETUP/ACCESS, wait states honoured) that connects directly to the NoC's `paddr/pwrite/pwdata/psel/penable/prdata/pready/pslverr`. It returns read data and error status to the granted requester with a one-cycle ack.

---
 rtl/apb_master_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin front end that sequences hold-until-ack
// requests from N_MASTER requesters onto one APB master interface.
module apb_master_arbiter #(
  parameter int A_WIDTH  = 32,
  parameter int WD_WIDTH = 32,
  parameter int RD_WIDTH = 32,
  parameter int N_MASTER = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rstn,
  input  logic [N_MASTER-1:0]          m_req,
  input  logic [N_MASTER-1:0]          m_write,
  input  logic [N_MASTER*A_WIDTH-1:0]  m_addr,
  input  logic [N_MASTER*WD_WIDTH-1:0] m_wdata,
  output logic [N_MASTER-1:0]          m_ack,
  output logic [RD_WIDTH-1:0]          m_rdata,
  output logic                         m_err,
  output logic [A_WIDTH-1:0]           paddr,
  output logic                         pwrite,
  output logic [WD_WIDTH-1:0]          pwdata,
  output logic                         psel,
  output logic                         penable,
  input  logic [RD_WIDTH-1:0]          prdata,
  input  logic                         pready,
  input  logic                         pslverr
);

  localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    last_grant_reg, last_grant_next;
  logic [IDX_W-1:0]    winner_reg, winner_next;
  logic [A_WIDTH-1:0]  paddr_reg, paddr_next;
  logic                pwrite_reg, pwrite_next;
  logic [WD_WIDTH-1:0] pwdata_reg, pwdata_next;
  logic                psel_reg, psel_next;
  logic                penable_reg, penable_next;
  logic [N_MASTER-1:0] m_ack_reg, m_ack_next;
  logic [RD_WIDTH-1:0] m_rdata_reg, m_rdata_next;
  logic                m_err_reg, m_err_next;

  logic [N_MASTER-1:0] eligible;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;

  // Round-robin search starting just after the last granted master; the master
  // being acked this cycle still holds m_req high, so it is masked out.
  always_comb begin
    eligible    = m_req & ~m_ack_reg;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= N_MASTER; k++) begin
      cand = int'(last_grant_reg) + k;
      if (cand >= N_MASTER) cand = cand - N_MASTER;
      cand_idx = IDX_W'(cand);
      if (!grant_valid && eligible[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    winner_next     = winner_reg;
    paddr_next      = paddr_reg;
    pwrite_next     = pwrite_reg;
    pwdata_next     = pwdata_reg;
    psel_next       = psel_reg;
    penable_next    = penable_reg;
    m_ack_next      = '0;
    m_rdata_next    = m_rdata_reg;
    m_err_next      = m_err_reg;
    case (state_reg)
      IDLE: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        if (grant_valid) begin
          paddr_next      = m_addr[grant_idx*A_WIDTH +: A_WIDTH];
          pwrite_next     = m_write[grant_idx];
          pwdata_next     = m_wdata[grant_idx*WD_WIDTH +: WD_WIDTH];
          winner_next     = grant_idx;
          last_grant_next = grant_idx;
          psel_next       = 1'b1;
          state_next      = SETUP;
        end
      end
      SETUP: begin
        psel_next    = 1'b1;
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_next    = 1'b0;
          penable_next = 1'b0;
          for (int i = 0; i < N_MASTER; i++) begin
            m_ack_next[i] = (winner_reg == IDX_W'(i));
          end
          m_err_next = pslverr;
          if (!pwrite_reg) m_rdata_next = prdata;
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        psel_next    = 1'b0;
        penable_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transfer.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(N_MASTER - 1);
      winner_reg     <= '0;
      paddr_reg      <= '0;
      pwrite_reg     <= 1'b0;
      pwdata_reg     <= '0;
      psel_reg       <= 1'b0;
      penable_reg    <= 1'b0;
      m_ack_reg      <= '0;
      m_rdata_reg    <= '0;
      m_err_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      winner_reg     <= winner_next;
      paddr_reg      <= paddr_next;
      pwrite_reg     <= pwrite_next;
      pwdata_reg     <= pwdata_next;
      psel_reg       <= psel_next;
      penable_reg    <= penable_next;
      m_ack_reg      <= m_ack_next;
      m_rdata_reg    <= m_rdata_next;
      m_err_reg      <= m_err_next;
    end
  end

  assign paddr   = paddr_reg;
  assign pwrite  = pwrite_reg;
  assign pwdata  = pwdata_reg;
  assign psel    = psel_reg;
  assign penable = penable_reg;
  assign m_ack   = m_ack_reg;
  assign m_rdata = m_rdata_reg;
  assign m_err   = m_err_reg;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed table, corner-case sequences and a
// randomized run checked against a transaction-level round-robin model.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rstn;
  logic [N-1:0]  m_req;
  logic [N-1:0]  m_write;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]  m_ack;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          psel;
  logic          penable;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  apb_master_arbiter #(.A_WIDTH(AW), .WD_WIDTH(DW), .RD_WIDTH(DW), .N_MASTER(N)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // APB slave model: wait count chosen at SETUP, response driven in ACCESS,
  // garbage on prdata/pslverr whenever pready is low.
  logic          rnd_mode = 1'b0;
  int            cfg_waits = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic          cfg_err = 1'b0;
  int            wait_left = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  initial begin
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
  end

  always @(negedge sys_clk) begin
    if (psel && !penable) wait_left = rnd_mode ? int'($urandom_range(0, 3)) : cfg_waits;
    if (psel && penable && wait_left == 0) begin
      last_rdata = rnd_mode ? $urandom : cfg_rdata;
      last_err   = rnd_mode ? 1'($urandom_range(0, 1)) : cfg_err;
      pready     = 1'b1;
      prdata     = last_rdata;
      pslverr    = last_err;
    end else begin
      if (psel && penable) wait_left = wait_left - 1;
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Step until an ack appears (bounded), then check which master and how long.
  task automatic expect_ack(input string name, input logic [N-1:0] exp_mask, input int exp_lat);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_ack == '0 && n < 60);
    check({name, "_ack"}, 64'(m_ack), 64'(exp_mask));
    check({name, "_lat"}, 64'(n), 64'(exp_lat));
    $display("txn %s: ack=%b after %0d cycles", name, m_ack, n);
  endtask

  typedef struct {
    int          master;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  exp_ack;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  // Transaction-level model state for the randomized run.
  int            remaining[N];
  logic          f_wr[N];
  logic [AW-1:0] f_addr[N];
  logic [DW-1:0] f_wdata[N];

  function automatic int rr_next(input int p);
    for (int k = 1; k <= N; k++) begin
      if (remaining[(p + k) % N] > 0) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic new_fields(input int i);
    f_wr[i]    = 1'($urandom_range(0, 1));
    f_addr[i]  = $urandom;
    f_wdata[i] = $urandom;
    m_write[i] = f_wr[i];
    m_addr[i*AW +: AW]  = f_addr[i];
    m_wdata[i*DW +: DW] = f_wdata[i];
  endtask

  initial begin
    logic [N-1:0] one;
    logic [DW-1:0] exp_rd;
    int p, cur, total, acks;

    one = 4'b0001;
    //            mst wr  addr          wdata         wt rdata         err ack      exp_rdata     exp_err
    vecs[0] = '{2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h1111_1111, 1'b0, 4'b0100, 32'h0000_0000, 1'b0};
    vecs[1] = '{0, 1'b0, 32'h0000_0020, 32'h0000_0000, 2, 32'hA5A5_0001, 1'b0, 4'b0001, 32'hA5A5_0001, 1'b0};
    vecs[2] = '{1, 1'b0, 32'h0000_0044, 32'h0000_0007, 1, 32'h1234_5678, 1'b1, 4'b0010, 32'h1234_5678, 1'b1};
    vecs[3] = '{3, 1'b1, 32'h0000_0088, 32'hCAFE_F00D, 0, 32'hFFFF_FFFF, 1'b0, 4'b1000, 32'h1234_5678, 1'b0};
    vecs[4] = '{3, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 3, 32'h0BAD_F00D, 1'b1, 4'b1000, 32'h0BAD_F00D, 1'b1};
    vecs[5] = '{2, 1'b1, 32'h0000_0000, 32'h0000_0001, 1, 32'h0000_0055, 1'b0, 4'b0100, 32'h0BAD_F00D, 1'b0};

    sys_rstn = 1'b0;
    m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0;
    repeat (3) step();

    // Reset values
    check("rst_psel", 64'(psel), 0);
    check("rst_penable", 64'(penable), 0);
    check("rst_pwrite", 64'(pwrite), 0);
    check("rst_m_ack", 64'(m_ack), 0);
    check("rst_m_err", 64'(m_err), 0);
    check("rst_paddr", 64'(paddr), 0);
    check("rst_pwdata", 64'(pwdata), 0);
    check("rst_m_rdata", 64'(m_rdata), 0);

    // Fairness: all masters request from reset release, order 0,1,2,3,0,1
    cfg_waits = 0; cfg_rdata = '0; cfg_err = 1'b0;
    for (int i = 0; i < N; i++) m_addr[i*AW +: AW] = 32'(i * 256);
    m_req = 4'hF;
    sys_rstn = 1'b1;
    for (int k = 0; k < 6; k++) expect_ack("fair", one << (k % N), 3);
    m_req = '0;
    repeat (2) step();

    // Directed table of single transfers
    for (int v = 0; v < 6; v++) begin
      cfg_waits = vecs[v].waits;
      cfg_rdata = vecs[v].rdata;
      cfg_err   = vecs[v].err;
      m_req = '0;
      m_req[vecs[v].master]   = 1'b1;
      m_write[vecs[v].master] = vecs[v].wr;
      m_addr[vecs[v].master*AW +: AW]  = vecs[v].addr;
      m_wdata[vecs[v].master*DW +: DW] = vecs[v].wdata;
      step();
      check("tbl_setup_psel", 64'(psel), 1);
      check("tbl_setup_penable", 64'(penable), 0);
      check("tbl_paddr", 64'(paddr), 64'(vecs[v].addr));
      check("tbl_pwrite", 64'(pwrite), 64'(vecs[v].wr));
      check("tbl_pwdata", 64'(pwdata), 64'(vecs[v].wdata));
      for (int w = 0; w <= vecs[v].waits; w++) begin
        step();
        check("tbl_access_psel", 64'(psel), 1);
        check("tbl_access_penable", 64'(penable), 1);
        check("tbl_access_paddr", 64'(paddr), 64'(vecs[v].addr));
        check("tbl_access_no_ack", 64'(m_ack), 0);
      end
      step();
      check("tbl_ack", 64'(m_ack), 64'(vecs[v].exp_ack));
      check("tbl_m_rdata", 64'(m_rdata), 64'(vecs[v].exp_rdata));
      check("tbl_m_err", 64'(m_err), 64'(vecs[v].exp_err));
      check("tbl_done_psel", 64'(psel), 0);
      $display("txn vec %0d: master %0d wr=%0d addr=0x%0h ack=%b rdata=0x%0h err=%0d",
               v, vecs[v].master, vecs[v].wr, vecs[v].addr, m_ack, m_rdata, m_err);
      m_req = '0;
      step();
      check("tbl_ack_pulse", 64'(m_ack), 0);
      check("tbl_idle_psel", 64'(psel), 0);
    end

    // Reset in the middle of an ACCESS phase
    cfg_waits = 5;
    m_req = 4'b0001; m_write[0] = 1'b0; m_addr[0 +: AW] = 32'h30;
    step();
    step();
    check("rst_mid_penable_before", 64'(penable), 1);
    sys_rstn = 1'b0;
    #1;
    check("rst_mid_psel", 64'(psel), 0);
    check("rst_mid_penable", 64'(penable), 0);
    check("rst_mid_m_ack", 64'(m_ack), 0);
    cfg_waits = 0;
    m_req = 4'b1010;
    step();
    step();
    sys_rstn = 1'b1;
    expect_ack("rst_m1", 4'b0010, 3);
    m_req[1] = 1'b0;
    expect_ack("rst_m3", 4'b1000, 3);
    // Pointer wrap: last grant was 3, masters 0 and 2 request
    m_req = 4'b0101;
    expect_ack("wrap_m0", 4'b0001, 3);
    m_req[0] = 1'b0;
    expect_ack("wrap_m2", 4'b0100, 3);
    m_req = '0;
    repeat (2) step();

    // Randomized run against the transaction-level model
    rnd_mode = 1'b1;
    sys_rstn = 1'b0;
    step();
    total = 0;
    for (int i = 0; i < N; i++) begin
      remaining[i] = int'($urandom_range(0, 4));
      if (i == 0 && remaining[i] == 0) remaining[i] = 1;
      total += remaining[i];
      m_req[i] = (remaining[i] > 0);
      new_fields(i);
    end
    sys_rstn = 1'b1;
    p = N - 1; cur = 0; acks = 0; exp_rd = '0;
    for (int cyc = 0; cyc < 3000 && acks < total; cyc++) begin
      step();
      if (psel && !penable) begin
        cur = rr_next(p);
        check("rnd_grant_valid", 64'(cur >= 0), 1);
        if (cur < 0) cur = 0;
        check("rnd_paddr", 64'(paddr), 64'(f_addr[cur]));
        check("rnd_pwrite", 64'(pwrite), 64'(f_wr[cur]));
        check("rnd_pwdata", 64'(pwdata), 64'(f_wdata[cur]));
      end
      if (m_ack != '0) begin
        check("rnd_ack", 64'(m_ack), 64'(one << cur));
        check("rnd_m_err", 64'(m_err), 64'(last_err));
        if (!f_wr[cur]) exp_rd = last_rdata;
        check("rnd_m_rdata", 64'(m_rdata), 64'(exp_rd));
        $display("txn rnd: master %0d wr=%0d addr=0x%0h err=%0d rdata=0x%0h",
                 cur, f_wr[cur], f_addr[cur], m_err, m_rdata);
        acks++;
        p = cur;
        remaining[cur]--;
        if (remaining[cur] > 0) new_fields(cur);
        else m_req[cur] = 1'b0;
      end
      // Idle requesters wiggle their inputs; the bus must not react.
      for (int i = 0; i < N; i++) begin
        if (remaining[i] == 0) m_addr[i*AW +: AW] = $urandom;
      end
    end
    check("rnd_all_done", 64'(acks), 64'(total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
